seq_detector_prog: RTL and testbench
====================================

Name: seq_detector_prog

Overview:
- Runtime-programmable serial pattern detector; next generation of the fixed 1010110 Moore detector.
- Pattern (up to MAX_LEN bits), length and overlap mode are loaded at run time.
- Registered Moore-style detection pulse; saturating match counter for the status/debug path.
- Sits on the same single-bit serial input stream as the fixed detector; reset pattern 1010110 makes it a drop-in replacement.

Parameters:
- MAX_LEN, 16, maximum pattern length in bits (>=2).
- LEN_W, 5, width of cfg_len; must hold MAX_LEN.
- CNT_W, 8, width of match_count.
- DEF_PATTERN, 16'h0056, pattern after reset; LSB-aligned, value 7'b1010110.
- DEF_LEN, 7, pattern length after reset.
- DEF_OVERLAP, 1, overlap mode after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = accept bits; 0 = hold all state, drop bits.
- in  in  1  serial data bit.
- in_valid  in  1  qualifies in; bit accepted when enable & in_valid & !cfg_load.
- cfg_load  in  1  load cfg_pattern/cfg_len/cfg_overlap this cycle.
- cfg_pattern  in  MAX_LEN  pattern, LSB-aligned; bit [len-1] is the first-received bit.
- cfg_len  in  LEN_W  pattern length, valid range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = non-overlapping.
- clear_cnt  in  1  synchronous clear of match_count and count_sat.
- detected  out  1  one-cycle pulse in the cycle after the completing bit's edge.
- match_count  out  CNT_W  number of matches, saturating.
- count_sat  out  1  sticky; set when match_count reaches all-ones.
- armed  out  1  fill >= len, so a match is possible on the next accepted bit.
- cfg_err  out  1  sticky; last cfg_load had an illegal cfg_len.

Behaviour:
- Reset (reset=0, async): hist=0, fill=0, detected=0, match_count=0, count_sat=0, armed=0, cfg_err=0; pattern/len/overlap = DEF_*.
- Accepted bit: hist <= {hist[MAX_LEN-2:0], in}; fill <= min(fill+1, len).
- Match condition, evaluated on the post-shift values: hist[len-1:0] == pattern[len-1:0] and fill == len. Bits above len are ignored.
- Match: detected registered to 1 for exactly one cycle.
- Match: match_count += 1 unless it is all-ones. count_sat goes to 1 on the same edge the count reaches all-ones.
- Detection latency: detected is high in the cycle immediately following the clock edge that accepted the last pattern bit. This matches the Moore timing of the fixed detector.
- Overlap=1: history retained after a match, so suffix/prefix overlaps detect.
- Overlap=0: on a match edge, hist <= 0 and fill <= 0; the next match needs len fresh bits.
- FSM (fill-derived): EMPTY (fill=0) -> FILLING (0<fill<len) -> ARMED (fill=len).
  - Overlap=0 match: ARMED -> EMPTY.
  - cfg_load: any state -> EMPTY.
  - armed = (state == ARMED).
- No accepted bit (enable=0 or in_valid=0): hist, fill and count hold; detected=0 next cycle.
- cfg_load with cfg_len in 1..MAX_LEN:
  - Latch pattern/len/overlap; clear hist and fill; clear cfg_err.
  - detected=0 next cycle; match_count untouched.
- cfg_load with cfg_len=0 or cfg_len>MAX_LEN:
  - Config unchanged; hist and fill not cleared; cfg_err <= 1.
  - The bit in that cycle is still dropped.
- cfg_load and in_valid in the same cycle: the load wins; the bit is dropped, not shifted.
- clear_cnt and a match in the same cycle: clear wins, so match_count=0 and count_sat=0. detected still pulses.
- len=1: every accepted bit equal to pattern[0] matches. Consecutive matches pulse detected on back-to-back cycles in both modes.
- enable deasserted mid-pattern: partial history retained; detection resumes when enable returns.
- Async reset mid-pattern: immediate return to reset values, including the default config.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset defaults; stream 1,0,1,0,1,1,0 with in_valid=1 -> detected=1 only in the cycle after the 7th bit; match_count=1; armed=1 from the 7th bit onward.
- Overlap=1: stream 1010110 then 10110 -> detected pulses after bit 7 and bit 12; count=2. Reload overlap=0, repeat -> single pulse after bit 7; count=3.
- Load pattern 4'b1111, len=4, overlap=1; send eight 1s -> detected high on the cycles after bits 4..8 (5 pulses). With overlap=0 -> pulses after bits 4 and 8 only.
- Toggle in_valid/enable low mid-pattern on 1010110 -> dropped cycles ignored; detection follows the 7th accepted bit. cfg_load with in_valid=1 in the same cycle -> that bit is dropped and fill=0.
- cfg_len=0 then cfg_len=MAX_LEN+1 -> cfg_err=1 and detection continues on the old pattern. Next valid load -> cfg_err=0.
- CNT_W=2: produce 4 matches -> count 1,2,3,3 with count_sat=1 from the 3rd match. clear_cnt coincident with a match -> count=0 and detected=1. Async reset mid-stream -> all outputs 0, pattern back to 1010110.

Source files
------------

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with a registered Moore-style detection pulse.
// Pattern, length and overlap mode load at run time; reset config is the 1010110 detector.
module seq_detector_prog #(
    parameter int unsigned           MAX_LEN     = 16,
    parameter int unsigned           LEN_W       = 5,
    parameter int unsigned           CNT_W       = 8,
    parameter logic [MAX_LEN-1:0]    DEF_PATTERN = MAX_LEN'(16'h0056),
    parameter int unsigned           DEF_LEN     = 7,
    parameter bit                    DEF_OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               clear_cnt,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat,
    output logic               armed,
    output logic               cfg_err
);

    typedef enum logic [1:0] {StEmpty, StFilling, StArmed} state_e;

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d, pat_q, pat_d;
    logic [MAX_LEN-1:0] hist_shift, mask;
    logic [LEN_W-1:0]   fill_q, fill_d, len_q, len_d, fill_inc;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovl_q, ovl_d, det_q, det_d, err_q, err_d, sat_q, sat_d;
    logic               accept, cfg_ok, match;

    assign accept     = enable & in_valid & ~cfg_load;
    assign cfg_ok     = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign hist_shift = {hist_q[MAX_LEN-2:0], in};
    assign fill_inc   = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);

    // Only the low len bits of history and pattern take part in the compare.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < 32'(len_q));
        end
    end

    assign match = accept && ((hist_shift & mask) == (pat_q & mask)) && (fill_inc == len_q);

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        err_d  = err_q;
        det_d  = 1'b0;
        if (cfg_load) begin
            if (cfg_ok) begin
                pat_d  = cfg_pattern;
                len_d  = cfg_len;
                ovl_d  = cfg_overlap;
                hist_d = '0;
                fill_d = '0;
                err_d  = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end else if (accept) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            det_d  = match;
            if (match && !ovl_q) begin
                hist_d = '0;
                fill_d = '0;
            end
        end
    end

    // Clear beats a coincident match; the count saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clear_cnt) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == '1) begin
                sat_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (fill_d == '0) begin
            state_d = StEmpty;
        end else if (fill_d < len_d) begin
            state_d = StFilling;
        end else begin
            state_d = StArmed;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= DEF_PATTERN;
            len_q  <= LEN_W'(DEF_LEN);
            ovl_q  <= DEF_OVERLAP;
            det_q  <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            det_q  <= det_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
        end
    end

    always_comb begin
        armed       = (state_q == StArmed);
        detected    = det_q;
        match_count = cnt_q;
        count_sat   = sat_q;
        cfg_err     = err_q;
    end

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench for seq_detector_prog: directed stimulus pushes hand-computed expectations,
// a monitor pops and compares one entry per clock. A CNT_W=2 twin shares the stimulus.
module tb_seq_detector_prog;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0, in_bit = 1'b0, in_valid = 1'b0, cfg_load = 1'b0;
    logic [15:0] cfg_pattern = '0;
    logic [4:0]  cfg_len = '0;
    logic        cfg_overlap = 1'b0, clear_cnt = 1'b0;
    logic        detected, count_sat, armed, cfg_err;
    logic [7:0]  match_count;
    logic        s_detected, s_count_sat, s_armed, s_cfg_err;
    logic [1:0]  s_match_count;

    always #5 clk = ~clk;

    seq_detector_prog u_dut (
        .clk(clk), .reset(reset), .enable(enable), .in(in_bit), .in_valid(in_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .clear_cnt(clear_cnt), .detected(detected),
        .match_count(match_count), .count_sat(count_sat), .armed(armed), .cfg_err(cfg_err)
    );

    seq_detector_prog #(.CNT_W(2)) u_small (
        .clk(clk), .reset(reset), .enable(enable), .in(in_bit), .in_valid(in_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .clear_cnt(clear_cnt), .detected(s_detected),
        .match_count(s_match_count), .count_sat(s_count_sat), .armed(s_armed),
        .cfg_err(s_cfg_err)
    );

    // m: [0] det, [1] cnt, [2] sat, [3] armed, [4] cfg_err, [5] small-instance count/sat
    typedef struct packed {
        logic [5:0] m;
        logic       det;
        logic [7:0] cnt;
        logic       sat;
        logic       arm;
        logic       err;
        logic [1:0] scnt;
        logic       ssat;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk1(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic en, input logic vld, input logic b, input logic ld,
                       input logic clr, input exp_t e);
        @(negedge clk);
        enable    = en;
        in_valid  = vld;
        in_bit    = b;
        cfg_load  = ld;
        clear_cnt = clr;
        q.push_back(e);
    endtask

    task automatic send(input logic b, input logic d);
        exp_t e = '0;
        e.m   = 6'b000001;
        e.det = d;
        cyc(1'b1, 1'b1, b, 1'b0, 1'b0, e);
    endtask

    // Bits and expected detect flags are listed first-sent at the MSB of the n-bit field.
    task automatic send_seq(input logic [31:0] bits, input int n, input logic [31:0] dets);
        for (int i = n - 1; i >= 0; i--) begin
            send(bits[i], dets[i]);
        end
    endtask

    task automatic status(input logic [7:0] cnt, input logic arm, input logic err);
        exp_t e = '0;
        e.m   = 6'b011011;
        e.cnt = cnt;
        e.arm = arm;
        e.err = err;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e);
    endtask

    task automatic load(input logic [15:0] pat, input logic [4:0] len, input logic ovl,
                        input logic vld, input logic b, input logic err, input logic arm);
        exp_t e = '0;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        e.m   = 6'b011001;
        e.err = err;
        e.arm = arm;
        cyc(1'b1, vld, b, 1'b1, 1'b0, e);
    endtask

    task automatic full(input logic b, input logic clr, input logic d, input logic [7:0] cnt,
                        input logic arm, input logic [1:0] scnt, input logic ssat);
        exp_t e = '0;
        e.m    = 6'b111111;
        e.det  = d;
        e.cnt  = cnt;
        e.sat  = 1'b0;
        e.arm  = arm;
        e.err  = 1'b0;
        e.scnt = scnt;
        e.ssat = ssat;
        cyc(1'b1, 1'b1, b, 1'b0, clr, e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                if (e.m[0]) chk1("detected", 8'(detected), 8'(e.det));
                if (e.m[1]) chk1("match_count", match_count, e.cnt);
                if (e.m[2]) chk1("count_sat", 8'(count_sat), 8'(e.sat));
                if (e.m[3]) chk1("armed", 8'(armed), 8'(e.arm));
                if (e.m[4]) chk1("cfg_err", 8'(cfg_err), 8'(e.err));
                if (e.m[5]) begin
                    chk1("small_count", 8'(s_match_count), 8'(e.scnt));
                    chk1("small_sat", 8'(s_count_sat), 8'(e.ssat));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        exp_t z = '0;
        z.m = 6'b111111;
        // Held in reset: everything zero.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, z);
        @(negedge clk);
        reset = 1'b1;

        // Default pattern, then overlapping second match.
        send_seq(32'b1010110, 7, 32'b0000001);
        status(8'd1, 1'b1, 1'b0);
        send_seq(32'b10110, 5, 32'b00001);
        status(8'd2, 1'b1, 1'b0);

        // Non-overlap reload; load cycle carries a valid bit that must be dropped.
        load(16'h0056, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        send_seq(32'b101011010110, 12, 32'b000000100000);
        status(8'd3, 1'b0, 1'b0);

        // 1111, overlap on then off.
        load(16'h000F, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_seq(32'b11111111, 8, 32'b00011111);
        status(8'd8, 1'b1, 1'b0);
        load(16'h000F, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_seq(32'b11111111, 8, 32'b00010001);
        status(8'd10, 1'b0, 1'b0);

        // Dropped cycles mid-pattern (enable low, then in_valid low).
        load(16'h0056, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_seq(32'b101, 3, 32'b000);
        z = '0; z.m = 6'b000001;
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, z);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, z);
        send_seq(32'b0110, 4, 32'b0001);
        status(8'd11, 1'b1, 1'b0);

        // Load with a coincident valid 1: that bit must not enter history.
        load(16'h0056, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send_seq(32'b010110, 6, 32'b000000);
        status(8'd11, 1'b0, 1'b0);

        // Illegal lengths keep config and partial history.
        load(16'h0056, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_seq(32'b101011, 6, 32'b000000);
        load(16'h000F, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        load(16'h000F, 5'd17, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b1);
        status(8'd12, 1'b1, 1'b1);
        load(16'h0056, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // len=1 in both modes: back-to-back pulses.
        load(16'h0001, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_seq(32'b1101, 4, 32'b1101);
        status(8'd15, 1'b0, 1'b0);
        load(16'h0001, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_seq(32'b11, 2, 32'b11);
        status(8'd17, 1'b1, 1'b0);

        // Saturation on the 2-bit twin, then clear coincident with a match.
        z = '0; z.m = 6'b100111;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, z);
        full(1'b1, 1'b0, 1'b1, 8'd1, 1'b1, 2'd1, 1'b0);
        full(1'b1, 1'b0, 1'b1, 8'd2, 1'b1, 2'd2, 1'b0);
        full(1'b1, 1'b0, 1'b1, 8'd3, 1'b1, 2'd3, 1'b1);
        full(1'b1, 1'b0, 1'b1, 8'd4, 1'b1, 2'd3, 1'b1);
        full(1'b1, 1'b1, 1'b1, 8'd0, 1'b1, 2'd0, 1'b0);

        // Async reset mid-stream restores the default pattern.
        load(16'h000F, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_seq(32'b111111, 6, 32'b000111);
        status(8'd3, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk1("async_armed", 8'(armed), 8'd0);
        chk1("async_count", match_count, 8'd0);
        z = '0; z.m = 6'b111111;
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, z);
        @(negedge clk);
        reset = 1'b1;
        send_seq(32'b1111, 4, 32'b0000);
        send_seq(32'b1010110, 7, 32'b0000001);
        status(8'd1, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        chk1("queue_drained", 8'(q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
